funnel_scheduler: RTL and testbench
===================================

# funnel_scheduler

Round-robin scheduler that sequences an N-input PipeOut funnel selector. It watches the per-input first__RDY lines and drives the selector's select method. It holds each grant for up to burstLen dequeues, then rotates fairly to the next ready input. It sits beside the funnel and exports a grant_valid qualifier that the downstream consumer ANDs into its deq enable.

## Interface
Parameters:
- funnelWidth, 8: number of funnel inputs; legal range 2..16, because the selector index field is 4 bits.
- burstLen, 4: maximum dequeues per grant; legal range ≥1.

Ports:
- CLK  input  1  clock; all state changes on posedge.
- nRST  input  1  reset, synchronous, active-low.
- req  input  funnelWidth  per-input first__RDY of the funnel inputs.
- deq_fire  input  1  funnel output deq__ENA && deq__RDY for this cycle.
- select__ENA  output  1  select method enable to the funnel.
- select$v  output  32  selected index; bits [3:0] carry the index, bits [31:4] are always 0.
- select__RDY  input  1  funnel select ready.
- grant_valid  output  1  the funnel index is settled on grant_index and dequeue is permitted.
- grant_index  output  4  currently granted input.
- protocol_err  output  1  sticky flag: deq_fire was seen while grant_valid=0.

## Operation
- States are IDLE, ISSUE and GRANT.
- Round-robin pointer last:
  - Reset value is funnelWidth-1, so the first search starts at input 0.
  - The search order is last+1, last+2, … modulo funnelWidth.
  - The winner is the first index whose req bit is 1.
- IDLE:
  - If any req bit is 1, register the winner into pend_index and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - select__ENA=1 and select$v={28'b0, pend_index}.
  - If select__RDY=1, go to GRANT with grant_index=pend_index, last=pend_index, beat count=0.
  - If select__RDY=0, hold select__ENA and pend_index and stay in ISSUE.
  - The req vector is not re-sampled in ISSUE; the chosen winner is committed.
- GRANT:
  - grant_valid=1. Each deq_fire increments count, whose width is clog2(burstLen+1).
  - Exit to IDLE on either of two events, evaluated in the same cycle:
    - (a) deq_fire with count==burstLen-1 (quantum expired);
    - (b) req[grant_index]==0 with deq_fire=0 (the input ran dry).
  - If both happen, exit only once and count the beat once.
  - count never exceeds burstLen.
- deq_fire outside GRANT is not counted and sets protocol_err. Only reset clears protocol_err.
- A single requester is re-granted after one IDLE bubble, because the round-robin search wraps to it.

## Timing
- Reset values:
  - state=IDLE;
  - select__ENA=0, select$v=0;
  - grant_valid=0, grant_index=0;
  - protocol_err=0, count=0, pend_index=0, last=funnelWidth-1.
- Reset asserted mid-grant aborts on the next edge to the reset values. No partial burst is remembered.
- Latency, with req rising in IDLE at cycle t:
  - select__ENA=1 in t+1, assuming select__RDY=1;
  - grant_valid=1 in t+2, which is the same cycle the funnel's registered index becomes valid.
- select__ENA is a decode of state==ISSUE, so it is high for exactly one cycle per grant when select__RDY=1.
- The last beat of a burst (deq_fire in GRANT) makes grant_valid=0 in the next cycle.
- Minimum grant-to-grant gap is 3 cycles: GRANT exit, then IDLE, then ISSUE.
- grant_valid is 0 in IDLE and ISSUE. The consumer must not dequeue in those cycles.

## Structure
- Package funnel_sched_pkg holds:
  - the typedef enum for the state (IDLE, ISSUE, GRANT);
  - the constant INDEX_WIDTH=4;
  - the constant SELECT_WIDTH=32.
- Sub-module rr_priority_pick is combinational:
  - inputs are req and last;
  - outputs are winner (4 bits) and any.
  - It is implemented as a rotate, a find-first and an un-rotate.
- The top level holds the FSM, the counter, the pointer and the error flag.

## Test plan
- Reset then req=8'h01, select__RDY=1, deq_fire every GRANT cycle:
  - select__ENA pulses once with select$v=0;
  - grant_valid is high for exactly 4 cycles;
  - then 1 IDLE cycle, then a re-grant of index 0.
- req=8'hFF held, continuous deq_fire: grant_index sequence is 0,1,2,…,7,0, each grant lasting 4 beats.
- req=8'h24 after a grant of index 2 (last=2): the next winner is 5 and the one after that is 2.
- select__RDY=0 for 3 cycles in ISSUE with pend_index=3:
  - select__ENA and select$v=3 are held all 3 cycles;
  - GRANT is entered on the cycle after select__RDY rises.
- Granted at index 1, after 2 beats req[1] drops with no deq_fire: return to IDLE, and grant_valid=0 on the next cycle.
- Two cases of deq_fire with state≠GRANT: a pulse in IDLE, and nRST=0 asserted in the middle of a GRANT.
  - The IDLE pulse sets protocol_err=1, which stays sticky.
  - The mid-GRANT reset returns protocol_err to 0 and all outputs to their reset values in 1 cycle.

Source files
------------

// File: rtl/funnel_sched_pkg.sv
// Shared types and widths for the funnel round-robin scheduler.
package funnel_sched_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, GRANT} sched_state_t;
   localparam int INDEX_WIDTH  = 4;
   localparam int SELECT_WIDTH = 32;
endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set req bit searching from last+1, wrapping.
module rr_priority_pick
   import funnel_sched_pkg::*;
#(
   parameter int funnelWidth = 8
) (
   input  logic [funnelWidth-1:0] req,
   input  logic [INDEX_WIDTH-1:0] last,
   output logic [INDEX_WIDTH-1:0] winner,
   output logic                   any
);
   logic [4:0]               start;
   logic [4:0]               off;
   logic [4:0]               sum;
   logic [2*funnelWidth-1:0] dbl;
   logic [funnelWidth-1:0]   rot;

   // Rotate so the search origin lands at bit 0, find-first, then un-rotate.
   always_comb begin
      start = (last >= INDEX_WIDTH'(funnelWidth-1)) ? 5'd0 : {1'b0, last} + 5'd1;
      dbl   = {req, req} >> start;
      rot   = dbl[funnelWidth-1:0];
      off   = 5'd0;
      for (int i = funnelWidth-1; i >= 0; i--) begin
         if (rot[i]) off = 5'(i);
      end
      sum    = start + off;
      winner = INDEX_WIDTH'((sum >= 5'(funnelWidth)) ? sum - 5'(funnelWidth) : sum);
      any    = |req;
   end
endmodule

// File: rtl/funnel_scheduler.sv
// Round-robin grant sequencer for an N-input PipeOut funnel selector.
module funnel_scheduler
   import funnel_sched_pkg::*;
#(
   parameter int funnelWidth = 8,
   parameter int burstLen    = 4
) (
   input  logic                    CLK,
   input  logic                    nRST,
   input  logic [funnelWidth-1:0]  req,
   input  logic                    deq_fire,
   output logic                    select__ENA,
   output logic [SELECT_WIDTH-1:0] select_v,
   input  logic                    select__RDY,
   output logic                    grant_valid,
   output logic [INDEX_WIDTH-1:0]  grant_index,
   output logic                    protocol_err
);
   localparam int CW = $clog2(burstLen+1);

   sched_state_t           state_q, state_d;
   logic [INDEX_WIDTH-1:0] pend_q, pend_d;
   logic [INDEX_WIDTH-1:0] gidx_q, gidx_d;
   logic [INDEX_WIDTH-1:0] last_q, last_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   perr_q, perr_d;
   logic [INDEX_WIDTH-1:0] winner;
   logic                   any;
   logic [15:0]            req_ext;
   logic                   quantum_done, ran_dry;

   rr_priority_pick #(.funnelWidth(funnelWidth)) u_pick (
      .req    (req),
      .last   (last_q),
      .winner (winner),
      .any    (any)
   );

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= IDLE;
         pend_q  <= '0;
         gidx_q  <= '0;
         last_q  <= INDEX_WIDTH'(funnelWidth-1);
         cnt_q   <= '0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         gidx_q  <= gidx_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         perr_q  <= perr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pend_d       = pend_q;
      gidx_d       = gidx_q;
      last_d       = last_q;
      cnt_d        = cnt_q;
      req_ext      = 16'(req);
      quantum_done = deq_fire && (cnt_q == CW'(burstLen-1));
      ran_dry      = !req_ext[gidx_q] && !deq_fire;
      perr_d       = perr_q | (deq_fire && (state_q != GRANT));
      case (state_q)
         IDLE: begin
            if (any) begin
               pend_d  = winner;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // Winner is committed; req is not re-sampled while the select stalls.
            if (select__RDY) begin
               state_d = GRANT;
               gidx_d  = pend_q;
               last_d  = pend_q;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            if (deq_fire) cnt_d = cnt_q + 1'b1;
            if (quantum_done || ran_dry) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign select__ENA  = (state_q == ISSUE);
   assign select_v     = select__ENA ? SELECT_WIDTH'(pend_q) : '0;
   assign grant_valid  = (state_q == GRANT);
   assign grant_index  = gidx_q;
   assign protocol_err = perr_q;
endmodule

// File: tb/tb_funnel_scheduler.sv
// Randomized + directed bench for funnel_scheduler against a behavioural model.
module tb_funnel_scheduler;
   localparam int N  = 8;
   localparam int BL = 4;

   logic          CLK = 1'b0;
   logic          nRST = 1'b0;
   logic [N-1:0]  req = '0;
   logic          deq_fire = 1'b0;
   logic          select__RDY = 1'b1;
   logic          select__ENA;
   logic [31:0]   select_v;
   logic          grant_valid;
   logic [3:0]    grant_index;
   logic          protocol_err;

   always #5 CLK = ~CLK;

   funnel_scheduler #(.funnelWidth(N), .burstLen(BL)) dut (
      .CLK          (CLK),
      .nRST         (nRST),
      .req          (req),
      .deq_fire     (deq_fire),
      .select__ENA  (select__ENA),
      .select_v     (select_v),
      .select__RDY  (select__RDY),
      .grant_valid  (grant_valid),
      .grant_index  (grant_index),
      .protocol_err (protocol_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Behavioural model: who is granted, how many beats taken, who is pending.
   typedef enum int {M_IDLE, M_ISSUE, M_GRANT} mph_t;
   mph_t ph = M_IDLE;
   int   pend = 0, gidx = 0, last = N-1, beats = 0;
   bit   merr = 0;
   bit   cmp_en = 0;

   task automatic model_step();
      if (!nRST) begin
         ph = M_IDLE; pend = 0; gidx = 0; last = N-1; beats = 0; merr = 0;
         return;
      end
      if (deq_fire && ph != M_GRANT) merr = 1;
      case (ph)
         M_IDLE: if (req != '0) begin
            for (int k = 1; k <= N; k++) begin
               if (req[(last+k)%N]) begin pend = (last+k)%N; break; end
            end
            ph = M_ISSUE;
         end
         M_ISSUE: if (select__RDY) begin
            ph = M_GRANT; gidx = pend; last = pend; beats = 0;
         end
         M_GRANT: begin
            if (deq_fire) beats++;
            if ((deq_fire && beats == BL) || (!req[gidx] && !deq_fire)) ph = M_IDLE;
         end
         default: ph = M_IDLE;
      endcase
   endtask

   always @(negedge CLK) begin
      if (cmp_en) begin
         chk("select__ENA", 32'(select__ENA), 32'(ph == M_ISSUE));
         chk("select_v", select_v, (ph == M_ISSUE) ? 32'(pend) : 32'd0);
         chk("grant_valid", 32'(grant_valid), 32'(ph == M_GRANT));
         chk("grant_index", 32'(grant_index), 32'(gidx));
         chk("protocol_err", 32'(protocol_err), 32'(merr));
      end
   end

   task automatic cycle(bit r, logic [N-1:0] rq, bit dq, bit rd);
      nRST = r; req = rq; deq_fire = dq; select__RDY = rd;
      @(posedge CLK);
      model_step();
      #1;
   endtask

   task automatic auto(logic [N-1:0] rq);
      cycle(1'b1, rq, ph == M_GRANT, 1'b1);
   endtask

   int q_log[$];
   task automatic run_log(logic [N-1:0] rq, int n);
      bit prev = 0;
      q_log.delete();
      cycle(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < n; i++) begin
         auto(rq);
         if (grant_valid && !prev) q_log.push_back(int'(grant_index));
         prev = grant_valid;
      end
   endtask

   initial begin
      int tot;
      int exp_rr[9];
      int exp_24[3];
      exp_rr = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
      exp_24 = '{2, 5, 2};

      // Reset values
      cycle(1'b0, '0, 1'b0, 1'b1);
      cmp_en = 1;
      chk("rst_ena", 32'(select__ENA), 32'd0);
      chk("rst_selv", select_v, 32'd0);
      chk("rst_gv", 32'(grant_valid), 32'd0);
      chk("rst_gidx", 32'(grant_index), 32'd0);
      chk("rst_perr", 32'(protocol_err), 32'd0);

      // Single requester: latency, burst length, one-bubble re-grant
      auto(8'h01);
      chk("t1_ena", 32'(select__ENA), 32'd1);
      chk("t1_selv", select_v, 32'd0);
      auto(8'h01);
      chk("t2_gv", 32'(grant_valid), 32'd1);
      tot = 1;
      for (int i = 0; i < 4; i++) begin
         auto(8'h01);
         tot += int'(grant_valid);
      end
      chk("burst_cycles", 32'(tot), 32'd4);
      chk("bubble_idle", 32'(select__ENA | grant_valid), 32'd0);
      auto(8'h01);
      chk("regrant_ena", 32'(select__ENA), 32'd1);
      auto(8'h01);
      chk("regrant_gv", 32'(grant_valid), 32'd1);
      chk("regrant_idx", 32'(grant_index), 32'd0);

      // All requesting: strict rotation
      run_log(8'hFF, 56);
      chk("rr_count", 32'(q_log.size() >= 9), 32'd1);
      if (q_log.size() >= 9)
         for (int i = 0; i < 9; i++) chk($sformatf("rr_seq%0d", i), 32'(q_log[i]), 32'(exp_rr[i]));

      // req=24: 2, then 5, then wrap back to 2
      run_log(8'h24, 20);
      chk("r24_count", 32'(q_log.size() >= 3), 32'd1);
      if (q_log.size() >= 3)
         for (int i = 0; i < 3; i++) chk($sformatf("r24_seq%0d", i), 32'(q_log[i]), 32'(exp_24[i]));

      // Select stall with pend_index=3; req change during stall is ignored
      cycle(1'b0, '0, 1'b0, 1'b1);
      cycle(1'b1, 8'h08, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("stall_ena", 32'(select__ENA), 32'd1);
         chk("stall_selv", select_v, 32'd3);
         if (i < 2) cycle(1'b1, 8'h09, 1'b0, 1'b0);
      end
      cycle(1'b1, 8'h09, 1'b0, 1'b1);
      chk("stall_gv", 32'(grant_valid), 32'd1);
      chk("stall_gidx", 32'(grant_index), 32'd3);

      // Input runs dry after 2 beats
      cycle(1'b0, '0, 1'b0, 1'b1);
      auto(8'h02); auto(8'h02);
      chk("dry_gidx", 32'(grant_index), 32'd1);
      cycle(1'b1, 8'h02, 1'b1, 1'b1);
      cycle(1'b1, 8'h02, 1'b1, 1'b1);
      chk("dry_still", 32'(grant_valid), 32'd1);
      cycle(1'b1, 8'h00, 1'b0, 1'b1);
      chk("dry_exit", 32'(grant_valid), 32'd0);

      // Stray deq in IDLE is sticky; reset mid-grant clears everything
      cycle(1'b0, '0, 1'b0, 1'b1);
      cycle(1'b1, '0, 1'b1, 1'b1);
      chk("perr_set", 32'(protocol_err), 32'd1);
      auto(8'h01); auto(8'h01); auto(8'h01);
      chk("perr_sticky", 32'(protocol_err), 32'd1);
      chk("mid_gv", 32'(grant_valid), 32'd1);
      cycle(1'b0, 8'h01, 1'b1, 1'b1);
      chk("mrst_gv", 32'(grant_valid), 32'd0);
      chk("mrst_perr", 32'(protocol_err), 32'd0);
      chk("mrst_ena", 32'(select__ENA), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [N-1:0] rq;
         bit dq;
         rq = req;
         if ($urandom_range(7) == 0) rq = N'($urandom);
         dq = (ph == M_GRANT) ? ($urandom_range(3) != 0) : ($urandom_range(150) == 0);
         cycle($urandom_range(300) != 0, rq, dq, $urandom_range(3) != 0);
      end

      cmp_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
